// File: rtl/id_stage_q.sv
// RV32I decode stage: small instruction queue, per-operand forwarding, load-use stall
// and a registered ID/EX output under a valid/ready handshake.
module id_stage_q #(
  parameter int XLEN     = 32,
  parameter int IQ_DEPTH = 2,
  parameter int FWD_N    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [31:0]           if_pc,
  input  logic [31:0]           if_inst,
  output logic [4:0]            rf_ra1,
  output logic [4:0]            rf_ra2,
  input  logic [XLEN-1:0]       rf_rd1,
  input  logic [XLEN-1:0]       rf_rd2,
  input  logic [FWD_N-1:0]      fwd_we,
  input  logic [5*FWD_N-1:0]    fwd_wa,
  input  logic [XLEN*FWD_N-1:0] fwd_wn,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [6:0]            ex_op,
  output logic [2:0]            ex_funct3,
  output logic                  ex_alt,
  output logic [4:0]            ex_rd,
  output logic                  ex_we,
  output logic [XLEN-1:0]       ex_rs1v,
  output logic [XLEN-1:0]       ex_rs2v,
  output logic [XLEN-1:0]       ex_imm,
  output logic [31:0]           ex_pc,
  output logic [31:0]           ex_tgt,
  output logic                  ex_illegal
);

  localparam int AW = $clog2(IQ_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // instruction queue
  logic [31:0]   r_q_pc   [IQ_DEPTH];
  logic [31:0]   r_q_inst [IQ_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_hazard;

  // output register
  logic            r_ex_valid;
  logic [6:0]      r_ex_op;
  logic [2:0]      r_ex_funct3;
  logic            r_ex_alt;
  logic [4:0]      r_ex_rd;
  logic            r_ex_we;
  logic [XLEN-1:0] r_ex_rs1v;
  logic [XLEN-1:0] r_ex_rs2v;
  logic [XLEN-1:0] r_ex_imm;
  logic [31:0]     r_ex_pc;
  logic [31:0]     r_ex_tgt;
  logic            r_ex_illegal;

  // head decode
  logic [31:0]     w_inst;
  logic [31:0]     w_pc;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_legal;
  logic            w_use1;
  logic            w_use2;
  logic            w_we;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [31:0]     w_tgt;

  // forwarding
  logic            w_f1_hit;
  logic            w_f2_hit;
  logic [XLEN-1:0] w_f1_val;
  logic [XLEN-1:0] w_f2_val;
  logic [XLEN-1:0] w_rs1v;
  logic [XLEN-1:0] w_rs2v;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign if_ready = !w_full && !rst;
  assign w_push   = if_valid && if_ready && !flush;

  assign w_inst = r_q_inst[r_rd_ptr[AW-1:0]];
  assign w_pc   = r_q_pc[r_rd_ptr[AW-1:0]];
  assign w_op   = w_inst[6:0];
  assign w_f3   = w_inst[14:12];
  assign w_rd   = w_inst[11:7];
  assign w_rs1  = w_inst[19:15];
  assign w_rs2  = w_inst[24:20];

  assign rf_ra1 = w_rs1;
  assign rf_ra2 = w_rs2;

  always_comb begin
    w_legal = 1'b1;
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_we    = 1'b0;
    w_imm32 = '0;
    case (w_op)
      OPC_LUI, OPC_AUIPC: begin
        w_we    = 1'b1;
        w_imm32 = {w_inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        w_we    = 1'b1;
        w_imm32 = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD: begin
        w_we    = 1'b1;
        w_use1  = 1'b1;
        w_imm32 = {{21{w_inst[31]}}, w_inst[30:20]};
      end
      OPC_BRANCH: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_imm32 = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
      end
      OPC_STORE: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_imm32 = {{21{w_inst[31]}}, w_inst[30:25], w_inst[11:7]};
      end
      OPC_OPIMM: begin
        w_we   = 1'b1;
        w_use1 = 1'b1;
        // shifts carry funct7 in the upper immediate bits; only shamt is the operand
        if (w_f3 == 3'b001 || w_f3 == 3'b101)
          w_imm32 = {27'b0, w_inst[24:20]};
        else
          w_imm32 = {{21{w_inst[31]}}, w_inst[30:20]};
      end
      OPC_OP: begin
        w_we   = 1'b1;
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        w_imm32 = {{21{w_inst[31]}}, w_inst[30:20]};
      end
      default: w_legal = 1'b0;
    endcase
    if (w_inst == 32'b0) w_legal = 1'b0;
    if (!w_legal) begin
      w_we    = 1'b0;
      w_use1  = 1'b0;
      w_use2  = 1'b0;
      w_imm32 = '0;
    end
  end

  assign w_imm = XLEN'($signed(w_imm32));
  assign w_tgt = (w_op == OPC_JAL || w_op == OPC_BRANCH) ? (w_pc + w_imm32) : (w_pc + 32'd4);

  // walk from the oldest source down so the lowest matching index wins
  always_comb begin
    w_f1_hit = 1'b0;
    w_f2_hit = 1'b0;
    w_f1_val = '0;
    w_f2_val = '0;
    for (int i = FWD_N - 1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_wa[5*i +: 5] == w_rs1) begin
        w_f1_hit = 1'b1;
        w_f1_val = fwd_wn[XLEN*i +: XLEN];
      end
      if (fwd_we[i] && fwd_wa[5*i +: 5] == w_rs2) begin
        w_f2_hit = 1'b1;
        w_f2_val = fwd_wn[XLEN*i +: XLEN];
      end
    end
  end

  assign w_rs1v = (!w_use1 || w_rs1 == 5'd0) ? '0 : (w_f1_hit ? w_f1_val : rf_rd1);
  assign w_rs2v = (!w_use2 || w_rs2 == 5'd0) ? '0 : (w_f2_hit ? w_f2_val : rf_rd2);

  assign w_hazard = r_ex_valid && (r_ex_op == OPC_LOAD) && (r_ex_rd != 5'd0) &&
                    ((w_use1 && r_ex_rd == w_rs1) || (w_use2 && r_ex_rd == w_rs2));

  assign w_pop = !w_empty && !w_hazard && (!r_ex_valid || ex_ready) && !flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr[AW-1:0]]   <= if_pc;
      r_q_inst[r_wr_ptr[AW-1:0]] <= if_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_op      <= '0;
      r_ex_funct3  <= '0;
      r_ex_alt     <= 1'b0;
      r_ex_rd      <= '0;
      r_ex_we      <= 1'b0;
      r_ex_rs1v    <= '0;
      r_ex_rs2v    <= '0;
      r_ex_imm     <= '0;
      r_ex_pc      <= '0;
      r_ex_tgt     <= '0;
      r_ex_illegal <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_pop) begin
      r_ex_valid   <= 1'b1;
      r_ex_op      <= w_op;
      r_ex_funct3  <= w_f3;
      r_ex_alt     <= w_inst[30];
      r_ex_rd      <= w_we ? w_rd : 5'd0;
      r_ex_we      <= w_we;
      r_ex_rs1v    <= w_rs1v;
      r_ex_rs2v    <= w_rs2v;
      r_ex_imm     <= w_imm;
      r_ex_pc      <= w_pc;
      r_ex_tgt     <= w_tgt;
      r_ex_illegal <= !w_legal;
    end else if (ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_op      = r_ex_op;
  assign ex_funct3  = r_ex_funct3;
  assign ex_alt     = r_ex_alt;
  assign ex_rd      = r_ex_rd;
  assign ex_we      = r_ex_we;
  assign ex_rs1v    = r_ex_rs1v;
  assign ex_rs2v    = r_ex_rs2v;
  assign ex_imm     = r_ex_imm;
  assign ex_pc      = r_ex_pc;
  assign ex_tgt     = r_ex_tgt;
  assign ex_illegal = r_ex_illegal;

endmodule

// File: tb/tb_id_stage_q.sv
// Directed bench for id_stage_q: decode, forwarding, load-use bubble, back-pressure,
// flush and illegal/branch-target vectors with hand-computed expectations.
module tb_id_stage_q;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [4:0]  rf_ra1;
  logic [4:0]  rf_ra2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_wa;
  logic [63:0] fwd_wn;
  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  ex_op;
  logic [2:0]  ex_funct3;
  logic        ex_alt;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic [31:0] ex_rs1v;
  logic [31:0] ex_rs2v;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc;
  logic [31:0] ex_tgt;
  logic        ex_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  id_stage_q #(.XLEN(32), .IQ_DEPTH(2), .FWD_N(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .fwd_we(fwd_we), .fwd_wa(fwd_wa), .fwd_wn(fwd_wn),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_funct3(ex_funct3),
    .ex_alt(ex_alt), .ex_rd(ex_rd), .ex_we(ex_we), .ex_rs1v(ex_rs1v), .ex_rs2v(ex_rs2v),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_tgt(ex_tgt), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // push one instruction, then let it move into the output register
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
    tick;
    if_valid = 1'b0;
    tick;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
    rf_rd1 = '0; rf_rd2 = '0; fwd_we = '0; fwd_wa = '0; fwd_wn = '0; ex_ready = 1'b1;
    tick;
    tick;
    check("rst_if_ready", if_ready, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_pc", ex_pc, 0);
    check("rst_ex_imm", ex_imm, 0);
    check("rst_ex_tgt", ex_tgt, 0);
    rst = 1'b0;
    #1;
    check("idle_if_ready", if_ready, 1);

    // ADDI x1,x0,5
    if_valid = 1'b1; if_pc = 32'h100; if_inst = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    tick;
    if_valid = 1'b0;
    check("t1_no_bypass", ex_valid, 0);
    tick;
    check("t1_valid", ex_valid, 1);
    check("t1_imm", ex_imm, 5);
    check("t1_rd", ex_rd, 1);
    check("t1_we", ex_we, 1);
    check("t1_tgt", ex_tgt, 32'h104);
    check("t1_op", ex_op, 7'h13);
    check("t1_rs1v", ex_rs1v, 0);
    tick;
    check("t1_bubble", ex_valid, 0);
    check("t1_hold_pc", ex_pc, 32'h100);

    // ADD x3,x1,x2 with both sources hitting x1: source 0 wins
    rf_rd1 = 32'd1; rf_rd2 = 32'd2;
    fwd_we = 2'b11; fwd_wa = {5'd1, 5'd1}; fwd_wn = {32'd9, 32'd7};
    if_valid = 1'b1; if_pc = 32'h104; if_inst = enc_r(5'd2, 5'd1, 5'd3);
    tick;
    if_valid = 1'b0;
    check("t2_ra1", rf_ra1, 1);
    check("t2_ra2", rf_ra2, 2);
    tick;
    check("t2_rs1v", ex_rs1v, 7);
    check("t2_rs2v", ex_rs2v, 2);
    check("t2_rd", ex_rd, 3);

    // ADD x4,x2,x1: only source 1 enabled (x1), source 0 names x2 but is disabled
    rf_rd1 = 32'd11; rf_rd2 = 32'd22;
    fwd_we = 2'b10; fwd_wa = {5'd1, 5'd2}; fwd_wn = {32'd9, 32'd99};
    issue(32'h108, enc_r(5'd1, 5'd2, 5'd4));
    check("t2b_rs1v", ex_rs1v, 11);
    check("t2b_rs2v", ex_rs2v, 9);

    // ADD x10,x0,x5 with a forward aimed at x0
    rf_rd1 = 32'h33; rf_rd2 = 32'h44;
    fwd_we = 2'b01; fwd_wa = {5'd0, 5'd0}; fwd_wn = {32'd0, 32'hDEAD};
    issue(32'h10C, enc_r(5'd5, 5'd0, 5'd10));
    check("x0_rs1v", ex_rs1v, 0);
    check("x0_rs2v", ex_rs2v, 32'h44);

    // LUI x9,0xABCDE: no register operands used
    fwd_we = 2'b00; rf_rd1 = 32'h77; rf_rd2 = 32'h88;
    issue(32'h500, {20'hABCDE, 5'd9, 7'b0110111});
    check("lui_imm", ex_imm, 32'hABCDE000);
    check("lui_rs1v", ex_rs1v, 0);
    check("lui_rs2v", ex_rs2v, 0);
    check("lui_tgt", ex_tgt, 32'h504);
    check("lui_rd", ex_rd, 9);

    // SRAI x8,x8,31: shamt only, alt bit set
    issue(32'h504, enc_i(12'h41F, 5'd8, 3'b101, 5'd8, 7'b0010011));
    check("srai_imm", ex_imm, 31);
    check("srai_alt", ex_alt, 1);
    check("srai_f3", ex_funct3, 5);
    check("srai_rs1v", ex_rs1v, 32'h77);
    check("srai_rs2v", ex_rs2v, 0);

    // SW x2,-4(x1): no rd even though the field is non-zero
    issue(32'h508, {7'b1111111, 5'd2, 5'd1, 3'b010, 5'b11100, 7'b0100011});
    check("sw_imm", ex_imm, 32'hFFFFFFFC);
    check("sw_we", ex_we, 0);
    check("sw_rd", ex_rd, 0);
    check("sw_rs2v", ex_rs2v, 32'h88);

    // JAL x1,+8 at the top of the address space wraps
    issue(32'hFFFFFFFC, enc_j(21'd8, 5'd1));
    check("jal_imm", ex_imm, 8);
    check("jal_tgt", ex_tgt, 32'h4);

    // LW x5,0(x0) then ADD x6,x5,x5: one bubble
    rf_rd1 = '0; rf_rd2 = '0;
    if_valid = 1'b1; if_pc = 32'h300; if_inst = enc_i(12'd0, 5'd0, 3'b010, 5'd5, 7'b0000011);
    tick;
    if_pc = 32'h304; if_inst = enc_r(5'd5, 5'd5, 5'd6);
    tick;
    if_valid = 1'b0;
    check("t3_ld_valid", ex_valid, 1);
    check("t3_ld_op", ex_op, 7'h03);
    check("t3_ld_rd", ex_rd, 5);
    fwd_we = 2'b01; fwd_wa = {5'd0, 5'd5}; fwd_wn = {32'd0, 32'h55};
    tick;
    check("t3_bubble", ex_valid, 0);
    tick;
    check("t3_add_valid", ex_valid, 1);
    check("t3_add_pc", ex_pc, 32'h304);
    check("t3_add_rs1v", ex_rs1v, 32'h55);
    check("t3_add_rs2v", ex_rs2v, 32'h55);
    fwd_we = 2'b00;
    tick;
    check("t3_drain", ex_valid, 0);

    // back-pressure: four stalled cycles, three pushes plus one refused
    if_valid = 1'b1; if_pc = 32'h400; if_inst = enc_i(12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011);
    tick;
    ex_ready = 1'b0;
    if_pc = 32'h404; if_inst = enc_i(12'd2, 5'd0, 3'b000, 5'd7, 7'b0010011);
    tick;
    check("t4_a_valid", ex_valid, 1);
    check("t4_a_pc", ex_pc, 32'h400);
    if_pc = 32'h408; if_inst = enc_i(12'd3, 5'd0, 3'b000, 5'd7, 7'b0010011);
    tick;
    check("t4_full", if_ready, 0);
    if_pc = 32'h40C; if_inst = enc_i(12'd4, 5'd0, 3'b000, 5'd7, 7'b0010011);
    tick;
    check("t4_hold_pc", ex_pc, 32'h400);
    check("t4_hold_imm", ex_imm, 1);
    check("t4_hold_valid", ex_valid, 1);
    check("t4_still_full", if_ready, 0);
    tick;
    check("t4_hold_imm2", ex_imm, 1);
    if_valid = 1'b0; ex_ready = 1'b1;
    tick;
    check("t4_b_pc", ex_pc, 32'h404);
    check("t4_b_imm", ex_imm, 2);
    check("t4_ready_again", if_ready, 1);
    tick;
    check("t4_c_pc", ex_pc, 32'h408);
    check("t4_c_imm", ex_imm, 3);
    tick;
    check("t4_drain", ex_valid, 0);
    tick;
    check("t4_no_d", ex_valid, 0);

    // flush with a full queue and an offered instruction
    ex_ready = 1'b0;
    if_valid = 1'b1; if_pc = 32'h600; if_inst = enc_i(12'd1, 5'd0, 3'b000, 5'd2, 7'b0010011);
    tick;
    if_pc = 32'h604;
    tick;
    if_pc = 32'h608;
    tick;
    check("t5_full", if_ready, 0);
    flush = 1'b1; if_pc = 32'h60C;
    tick;
    flush = 1'b0; if_valid = 1'b0;
    check("t5_ex_valid", ex_valid, 0);
    check("t5_if_ready", if_ready, 1);
    ex_ready = 1'b1;
    tick;
    check("t5_empty", ex_valid, 0);

    // all-zero word, then BEQ x1,x2,-8 at 0x200
    rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    if_valid = 1'b1; if_pc = 32'h1FC; if_inst = 32'h0;
    tick;
    if_pc = 32'h200; if_inst = enc_b(13'h1FF8, 5'd2, 5'd1);
    tick;
    if_valid = 1'b0;
    check("t6_ill", ex_illegal, 1);
    check("t6_ill_we", ex_we, 0);
    check("t6_ill_rd", ex_rd, 0);
    check("t6_ill_valid", ex_valid, 1);
    tick;
    check("t6_beq_ill", ex_illegal, 0);
    check("t6_beq_tgt", ex_tgt, 32'h1F8);
    check("t6_beq_imm", ex_imm, 32'hFFFFFFF8);
    check("t6_beq_we", ex_we, 0);
    check("t6_beq_rs1v", ex_rs1v, 32'h11);
    check("t6_beq_rs2v", ex_rs2v, 32'h22);
    tick;
    check("t6_drain", ex_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
